// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, keeps one imem read in flight and hands words to decode.
// Slot output is registered (1 cycle after rvalid); a full undrained slot parks the FSM in HOLD with no request.
module fetch_pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_adel
);

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_ADEL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              adel;
  } slot_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] next_pc, next_pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_pc_nxt;
  logic              kill, kill_nxt;
  logic              slot_vld, slot_vld_nxt;
  slot_t             slot, slot_nxt;
  logic              misaligned;
  logic              slot_free;
  logic              drain;

  assign misaligned = (next_pc[1:0] != 2'b00);
  assign slot_free  = !slot_vld || if_ready;
  // The address-error slot is sticky: it stays presented until a flush.
  assign drain      = slot_vld && if_ready && (state != ST_ADEL);

  assign imem_addr = next_pc;
  assign if_valid  = slot_vld;
  assign if_pc     = slot.pc;
  assign if_instr  = slot.instr;
  assign if_adel   = slot.adel;

  always_comb begin
    state_nxt    = state;
    next_pc_nxt  = next_pc;
    req_pc_nxt   = req_pc;
    kill_nxt     = kill;
    slot_vld_nxt = slot_vld && !drain;
    slot_nxt     = slot;
    imem_req     = 1'b0;

    // A killed read is retired by whichever rvalid comes back first.
    if (kill && imem_rvalid) begin
      kill_nxt = 1'b0;
    end

    case (state)
      ST_ISSUE: begin
        if (!kill) begin
          if (!slot_free) begin
            state_nxt = ST_HOLD;
          end else if (misaligned) begin
            state_nxt    = ST_ADEL;
            slot_vld_nxt = 1'b1;
            slot_nxt     = '{pc: next_pc, instr: 32'h0, adel: 1'b1};
          end else begin
            imem_req = 1'b1;
            if (imem_gnt) begin
              state_nxt   = ST_WAIT;
              req_pc_nxt  = next_pc;
              next_pc_nxt = next_pc + ADDR_W'(4);
            end
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            state_nxt = ST_ISSUE;
          end else begin
            slot_vld_nxt = 1'b1;
            slot_nxt     = '{pc: req_pc, instr: imem_rdata, adel: 1'b0};
            state_nxt    = if_ready ? ST_ISSUE : ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (if_ready) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ADEL: begin
        state_nxt = ST_ADEL;
      end
    endcase

    if (br_valid && (state != ST_ADEL) && (state_nxt != ST_ADEL)) begin
      next_pc_nxt = br_target;
    end

    // Flush beats everything; an in-flight read must still drain before the next issue.
    if (flush) begin
      imem_req     = 1'b0;
      next_pc_nxt  = flush_pc;
      slot_vld_nxt = 1'b0;
      if ((state == ST_WAIT) && !imem_rvalid) begin
        state_nxt = ST_WAIT;
        kill_nxt  = 1'b1;
      end else begin
        state_nxt = ST_ISSUE;
      end
    end

    if (rst) begin
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ISSUE;
      next_pc  <= RESET_PC;
      req_pc   <= '0;
      kill     <= (state == ST_WAIT) && !imem_rvalid;
      slot_vld <= 1'b0;
      slot     <= '0;
    end else begin
      state    <= state_nxt;
      next_pc  <= next_pc_nxt;
      req_pc   <= req_pc_nxt;
      kill     <= kill_nxt;
      slot_vld <= slot_vld_nxt;
      slot     <= slot_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; the imem model returns ~addr as the instruction word, in order.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_target(br_target),
    .flush(flush), .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_adel(if_adel)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int g_lat    = 0;
  int r_lat    = 1;
  bit rnd      = 1'b0;
  int ncyc     = 0;
  int g_wait   = 0;
  int last_due = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] gnt_log[$];

  // Memory model: grants after g_wait cycles of request, returns data in order r_lat+ cycles later.
  initial begin : imem_model
    int lat;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      ncyc++;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      if (q_addr.size() > 0 && q_due[0] <= ncyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~q_addr[0];
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_req) begin
        if (g_wait > 0) begin
          g_wait--;
        end else begin
          imem_gnt = 1'b1;
          lat = rnd ? int'($urandom_range(1, 5)) : r_lat;
          last_due = (ncyc + lat > last_due + 1) ? ncyc + lat : last_due + 1;
          q_addr.push_back(imem_addr);
          q_due.push_back(last_due);
          gnt_log.push_back(imem_addr);
          g_wait = rnd ? int'($urandom_range(0, 4)) : g_lat;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a presented slot, checks it, then lets the handshake edge pass.
  task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic adel, output int waited);
    waited = 0;
    while (!if_valid && waited < 40) begin
      cyc();
      waited++;
    end
    chk({tag, "_vld"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, ins);
    chk({tag, "_adel"}, 32'(if_adel), 32'(adel));
    cyc();
  endtask

  initial begin : stim
    int w;
    int base;
    rst = 1'b1; br_valid = 1'b0; br_target = 32'h0; flush = 1'b0; flush_pc = 32'h0; if_ready = 1'b0;
    repeat (3) cyc();

    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_vld", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_adel", 32'(if_adel), 32'd0);

    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    // Sequential fetch with 1-cycle memory, decode always ready.
    if_ready = 1'b1;
    expect_fetch("t1_a", 32'h3000, ~32'h3000, 1'b0, w);
    expect_fetch("t1_b", 32'h3004, ~32'h3004, 1'b0, w);
    chk("t1_gap_b", 32'(w <= 1), 32'd1);
    expect_fetch("t1_c", 32'h3008, ~32'h3008, 1'b0, w);
    chk("t1_gap_c", 32'(w <= 1), 32'd1);
    chk("t1_req0", gnt_log[0], 32'h3000);
    chk("t1_req1", gnt_log[1], 32'h3004);
    chk("t1_req2", gnt_log[2], 32'h3008);

    // Decode stall with the slot full.
    if_ready = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t2_vld", 32'(if_valid), 32'd1);
      chk("t2_pc", if_pc, 32'h300C);
      chk("t2_instr", if_instr, ~32'h300C);
      chk("t2_req", 32'(imem_req), 32'd0);
      cyc();
    end
    if_ready = 1'b1;
    expect_fetch("t2_a", 32'h300C, ~32'h300C, 1'b0, w);
    expect_fetch("t2_b", 32'h3010, ~32'h3010, 1'b0, w);

    // Redirect while the delay slot 0x3014 is in flight.
    base = gnt_log.size();
    br_valid = 1'b1; br_target = 32'h3100;
    cyc();
    br_valid = 1'b0;
    expect_fetch("t3_dslot", 32'h3014, ~32'h3014, 1'b0, w);
    r_lat = 3;
    expect_fetch("t3_tgt", 32'h3100, ~32'h3100, 1'b0, w);
    chk("t3_req_dslot", gnt_log[base - 1], 32'h3014);
    chk("t3_req_tgt", gnt_log[base], 32'h3100);

    // Flush while 0x3104 is outstanding.
    flush = 1'b1; flush_pc = 32'h0000_0380; r_lat = 1;
    cyc();
    flush = 1'b0;
    chk("t4_vld", 32'(if_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd0);
    expect_fetch("t4_new", 32'h0380, ~32'h0380, 1'b0, w);

    // Misaligned redirect target.
    br_valid = 1'b1; br_target = 32'h3102;
    cyc();
    br_valid = 1'b0;
    expect_fetch("t5_dslot", 32'h0384, ~32'h0384, 1'b0, w);
    expect_fetch("t5_adel", 32'h3102, 32'h0, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      br_valid = (i == 1);
      br_target = 32'h3200;
      chk("t5_req", 32'(imem_req), 32'd0);
      chk("t5_vld", 32'(if_valid), 32'd1);
      chk("t5_adel_hold", 32'(if_adel), 32'd1);
      chk("t5_pc_hold", if_pc, 32'h3102);
      cyc();
    end
    br_valid = 1'b0;

    // Wrap at the top of the address space with random memory timing.
    base = gnt_log.size();
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC; rnd = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t6_flush_vld", 32'(if_valid), 32'd0);
    expect_fetch("t6_top", 32'hFFFF_FFFC, ~32'hFFFF_FFFC, 1'b0, w);
    expect_fetch("t6_wrap", 32'h0000_0000, ~32'h0000_0000, 1'b0, w);
    expect_fetch("t6_next", 32'h0000_0004, ~32'h0000_0004, 1'b0, w);
    chk("t6_req_top", gnt_log[base], 32'hFFFF_FFFC);
    chk("t6_req_wrap", gnt_log[base + 1], 32'h0000_0000);

    // Flush and redirect in the same cycle.
    flush = 1'b1; flush_pc = 32'h0000_0500; br_valid = 1'b1; br_target = 32'h0000_0700;
    rnd = 1'b0; g_wait = 0; r_lat = 3;
    cyc();
    flush = 1'b0; br_valid = 1'b0;
    chk("t6_fb_vld", 32'(if_valid), 32'd0);
    expect_fetch("t6_fb", 32'h0500, ~32'h0500, 1'b0, w);

    // Reset while 0x504 is outstanding; its late data must not surface.
    rst = 1'b1;
    cyc();
    rst = 1'b0; r_lat = 1;
    #1;
    chk("t7_vld", 32'(if_valid), 32'd0);
    chk("t7_pc", if_pc, 32'h0);
    chk("t7_instr", if_instr, 32'h0);
    expect_fetch("t7_restart", 32'h3000, ~32'h3000, 1'b0, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
